td4_base_core: RTL and testbench

TD4_BASE_CORE -- requirements
Module: td4_base_core

---
 rtl/td4_pkg.sv | 27 ++
 rtl/td4_alu.sv | 29 ++
 rtl/td4_base_core.sv | 101 ++++++++++
 tb/tb_td4_base_core.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// TD4 shared definitions: data nibble type, opcode constants, ALU source select.
// Optional build macro TD4_CARRY_HOLD_EN is consumed by td4_base_core.
package td4_pkg;

  typedef logic [3:0] nib_t;

  localparam nib_t OP_ADD_A    = 4'b0000;
  localparam nib_t OP_MOV_AB   = 4'b0001;
  localparam nib_t OP_IN_A     = 4'b0010;
  localparam nib_t OP_MOV_A_IM = 4'b0011;
  localparam nib_t OP_MOV_BA   = 4'b0100;
  localparam nib_t OP_ADD_B    = 4'b0101;
  localparam nib_t OP_IN_B     = 4'b0110;
  localparam nib_t OP_MOV_B_IM = 4'b0111;
  localparam nib_t OP_OUT_B    = 4'b1001;
  localparam nib_t OP_OUT_IM   = 4'b1011;
  localparam nib_t OP_JNC      = 4'b1110;
  localparam nib_t OP_JMP      = 4'b1111;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_sel_e;

endpackage

// File: rtl/td4_alu.sv
// TD4 ALU: selects A, B, input port or zero and adds the immediate.
// Purely combinational; sum wraps mod 16 and carry_o is the bit-3 carry-out.
module td4_alu
  import td4_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] in_i,
  input  logic [3:0] im_i,
  input  src_sel_e   sel_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  logic [3:0] src;

  always_comb begin
    src = 4'd0;
    case (sel_i)
      SRC_A:    src = a_i;
      SRC_B:    src = b_i;
      SRC_IN:   src = in_i;
      default:  src = 4'd0;
    endcase
  end

  assign {carry_o, sum_o} = {1'b0, src} + {1'b0, im_i};

endmodule

// File: rtl/td4_base_core.sv
// TD4 4-bit CPU core: single-cycle decode/execute against an external ROM, PC drives addr_rom.
// Build macro TD4_CARRY_HOLD_EN: carry changes only on ADD A/ADD B instead of every instruction.
module td4_base_core
  import td4_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] in,
  input  logic [7:0] data_rom,
  output logic [3:0] out,
  output logic [3:0] addr_rom
);

  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic [3:0] pc_q, pc_d;
  logic       c_q, c_d;

  nib_t       op;
  nib_t       im;
  src_sel_e   src_sel;
  logic       wr_a, wr_b, wr_out, jump, is_add;
  logic [3:0] sum;
  logic       carry;

  assign op = data_rom[7:4];
  assign im = data_rom[3:0];

  always_comb begin
    src_sel = SRC_ZERO;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    wr_out  = 1'b0;
    jump    = 1'b0;
    is_add  = 1'b0;
    case (op)
      OP_ADD_A:    begin src_sel = SRC_A;  wr_a = 1'b1; is_add = 1'b1; end
      OP_ADD_B:    begin src_sel = SRC_B;  wr_b = 1'b1; is_add = 1'b1; end
      OP_MOV_A_IM: begin src_sel = SRC_ZERO; wr_a = 1'b1; end
      OP_MOV_B_IM: begin src_sel = SRC_ZERO; wr_b = 1'b1; end
      OP_MOV_AB:   begin src_sel = SRC_B;  wr_a = 1'b1; end
      OP_MOV_BA:   begin src_sel = SRC_A;  wr_b = 1'b1; end
      OP_IN_A:     begin src_sel = SRC_IN; wr_a = 1'b1; end
      OP_IN_B:     begin src_sel = SRC_IN; wr_b = 1'b1; end
      OP_OUT_B:    begin src_sel = SRC_B;  wr_out = 1'b1; end
      OP_OUT_IM:   begin src_sel = SRC_ZERO; wr_out = 1'b1; end
      OP_JMP:      jump = 1'b1;
      // JNC looks at the carry left by the previous instruction
      OP_JNC:      jump = ~c_q;
      default:     ;
    endcase
  end

  td4_alu u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .in_i    (in),
    .im_i    (im),
    .sel_i   (src_sel),
    .sum_o   (sum),
    .carry_o (carry)
  );

  always_comb begin
    a_d   = wr_a   ? sum : a_q;
    b_d   = wr_b   ? sum : b_q;
    out_d = wr_out ? sum : out_q;
    pc_d  = jump   ? im  : pc_q + 4'd1;
`ifdef TD4_CARRY_HOLD_EN
    c_d   = is_add ? carry : c_q;
`else
    c_d   = carry;
`endif
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      a_q   <= 4'd0;
      b_q   <= 4'd0;
      out_q <= 4'd0;
      pc_q  <= 4'd0;
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      pc_q  <= pc_d;
      c_q   <= c_d;
    end
  end

  assign out      = out_q;
  assign addr_rom = pc_q;

`ifndef TD4_CARRY_HOLD_EN
  logic unused_is_add;
  assign unused_is_add = is_add;
`endif

endmodule

// File: tb/tb_td4_base_core.sv
// Bench for td4_base_core: directed program fragments, then random instruction streams
// compared every cycle against an arithmetic model of the TD4 instruction set.
module tb_td4_base_core;

  logic       clk;
  logic       clr_n;
  logic [3:0] in;
  logic [7:0] data_rom;
  logic [3:0] out;
  logic [3:0] addr_rom;

  int checks = 0;
  int errors = 0;

  // reference machine state
  int m_a, m_b, m_out, m_pc, m_c;

  td4_base_core dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .in       (in),
    .data_rom (data_rom),
    .out      (out),
    .addr_rom (addr_rom)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hold_carry();
`ifdef TD4_CARRY_HOLD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Instruction-set semantics written as plain arithmetic on integers.
  task automatic model(input bit rst, input int op, input int im, input int inv);
    int s;
    int next_pc;
    bit adds;
    if (rst) begin
      m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_c = 0;
      return;
    end
    s = im;
    adds = 0;
    next_pc = (m_pc + 1) % 16;
    case (op)
      0:  begin s = m_a + im; m_a = s % 16; adds = 1; end
      5:  begin s = m_b + im; m_b = s % 16; adds = 1; end
      3:  m_a = im;
      7:  m_b = im;
      1:  begin s = m_b + im; m_a = s % 16; end
      4:  begin s = m_a + im; m_b = s % 16; end
      2:  begin s = inv + im; m_a = s % 16; end
      6:  begin s = inv + im; m_b = s % 16; end
      9:  begin s = m_b + im; m_out = s % 16; end
      11: m_out = im;
      15: next_pc = im;
      14: if (m_c == 0) next_pc = im;
      default: s = 0;
    endcase
    m_pc = next_pc;
    if (!hold_carry() || adds) m_c = (s > 15) ? 1 : 0;
  endtask

  task automatic step(input bit rst, input int op, input int im, input int inv);
    clr_n    = ~rst;
    data_rom = {op[3:0], im[3:0]};
    in       = inv[3:0];
    model(rst, op, im, inv);
    @(posedge clk);
    #1;
    chk("out", out, m_out[3:0]);
    chk("addr_rom", addr_rom, m_pc[3:0]);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, $urandom_range(15), $urandom_range(15), 0);
  endtask

  initial begin
    clr_n = 1'b0; in = 4'd0; data_rom = 8'h00;
    m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_c = 0;
    #1;

    // reset, then IN A / ADD A,2 / MOV B,A / OUT B
    do_reset(3);
    chk("rst_out", out, 4'b0000);
    chk("rst_addr", addr_rom, 4'b0000);
    step(0, 4'b0010, 0, 4'b1010);
    step(0, 4'b0000, 2, 0);
    step(0, 4'b0100, 0, 0);
    step(0, 4'b1001, 0, 0);
    chk("prog1_out", out, 4'b1100);
    chk("prog1_addr", addr_rom, 4'd4);

    // register moves through B and A
    do_reset(1);
    step(0, 4'b0110, 0, 4'b0101);
    step(0, 4'b0001, 0, 0);
    step(0, 4'b0111, 8, 0);
    step(0, 4'b0101, 2, 0);
    step(0, 4'b1001, 0, 0);
    chk("prog2_out_a", out, 4'b1010);
    step(0, 4'b0100, 0, 0);
    step(0, 4'b1001, 0, 0);
    chk("prog2_out_b", out, 4'b0101);

    // branches
    do_reset(1);
    step(0, 4'b0011, 3, 0);
    step(0, 4'b1110, 8, 0);
    chk("jnc_taken", addr_rom, 4'd8);
    step(0, 4'b0000, 13, 0);
    step(0, 4'b1110, 8, 0);
    chk("jnc_not_taken", addr_rom, 4'd10);
    step(0, 4'b1111, 4, 0);
    chk("jmp", addr_rom, 4'd4);
    step(0, 4'b1011, 1, 0);
    chk("out_im", out, 4'b0001);
    step(0, 4'b0100, 0, 0);
    step(0, 4'b1001, 0, 0);
    chk("add_wrap_a0", out, 4'b0000);

    // PC wrap after 16 instructions
    do_reset(1);
    for (int i = 0; i < 16; i++) step(0, 4'b0000, 0, 0);
    chk("pc_wrap", addr_rom, 4'd0);

    // reset mid-program with carry set
    step(0, 4'b1011, 12, 0);
    chk("pre_rst_out", out, 4'b1100);
    step(0, 4'b0011, 1, 0);
    step(0, 4'b0000, 15, 0);
    step(1, 4'b1011, 7, 0);
    chk("mid_rst_out", out, 4'd0);
    chk("mid_rst_addr", addr_rom, 4'd0);
    step(0, 4'b1110, 7, 0);
    chk("mid_rst_c0", addr_rom, 4'd7);

    // carry preserved or cleared across a non-ADD instruction
    do_reset(1);
    step(0, 4'b0011, 1, 0);
    step(0, 4'b0000, 15, 0);
    step(0, 4'b0111, 0, 0);
    step(0, 4'b1110, 8, 0);
    chk("carry_cfg", addr_rom, hold_carry() ? 4'd4 : 4'd8);

    // random instruction streams with occasional resets
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(31) == 0), $urandom_range(15), $urandom_range(15),
           $urandom_range(15));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
